core2_result_writeback: RTL and testbench

CORE2_RESULT_WRITEBACK -- requirements
Module: core2_result_writeback

---
 rtl/core2_result_writeback.sv | 123 ++++++++++++
 tb/tb_core2_result_writeback.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core2_result_writeback.sv
// rtl/core2_result_writeback.sv - drains 256-bit Core2 results into a 128-bit memory as lo/hi beat pairs
module core2_result_writeback #(
   parameter int DATA   = 256,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [CNT_W-1:0]    count,
   input  logic                fifo_empty,
   input  logic [DATA-1:0]     fifo_data,
   output logic                fifo_rd_en,
   output logic                mem_wr_en,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA/2-1:0]   mem_wr_data,
   input  logic                mem_ready,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    result_cnt
);

   localparam int HALF = DATA / 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WR_LO = 3'd3,
      S_WR_HI = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [CNT_W-1:0]    result_cnt_q, result_cnt_d;
   logic [DATA-1:0]     result_q, result_d;

   // Next-state and datapath updates; a write beat advances only when mem_ready accepts it
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      remaining_d  = remaining_q;
      result_cnt_d = result_cnt_q;
      result_d     = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ptr_d        = base_addr;
               remaining_d  = count;
               result_cnt_d = '0;
               state_d      = (count == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            // The pop itself is the combinational fifo_rd_en below
            if (!fifo_empty) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            result_d = fifo_data;
            state_d  = S_WR_LO;
         end
         S_WR_LO: begin
            if (mem_ready) begin
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = S_WR_HI;
            end
         end
         S_WR_HI: begin
            if (mem_ready) begin
               ptr_d        = ptr_q + ADDR_W'(1);
               result_cnt_d = result_cnt_q + CNT_W'(1);
               remaining_d  = remaining_q - CNT_W'(1);
               state_d      = (remaining_q == CNT_W'(1)) ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transfer in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         remaining_q  <= '0;
         result_cnt_q <= '0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         remaining_q  <= remaining_d;
         result_cnt_q <= result_cnt_d;
         result_q     <= result_d;
      end
   end

   // Outputs decode from state and registers only; fifo_rd_en alone looks at fifo_empty
   always_comb begin
      fifo_rd_en  = (state_q == S_READ) && !fifo_empty;
      mem_wr_en   = (state_q == S_WR_LO) || (state_q == S_WR_HI);
      mem_addr    = mem_wr_en ? ptr_q : '0;
      mem_wr_data = '0;
      if (state_q == S_WR_LO) begin
         mem_wr_data = result_q[HALF-1:0];
      end else if (state_q == S_WR_HI) begin
         mem_wr_data = result_q[DATA-1:HALF];
      end
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      result_cnt = result_cnt_q;
   end

endmodule

// File: tb/tb_core2_result_writeback.sv
// tb/tb_core2_result_writeback.sv - scoreboard bench for core2_result_writeback
module tb_core2_result_writeback;

   typedef struct {
      logic [15:0]  addr;
      logic [127:0] data;
   } wr_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [15:0]   base_addr;
   logic [7:0]    count;
   logic          fifo_empty = 1'b1;
   logic [255:0]  fifo_data  = '0;
   logic          fifo_rd_en;
   logic          mem_wr_en;
   logic [15:0]   mem_addr;
   logic [127:0]  mem_wr_data;
   logic          mem_ready;
   logic          busy;
   logic          done;
   logic [7:0]    result_cnt;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            pops = 0;
   int            writes = 0;
   int            stalls = 0;
   int            last_pop_cyc = -1;

   wr_t           exp_wr_q[$];
   int            exp_done_cyc_q[$];
   int            exp_done_cnt_q[$];
   logic [255:0]  fifo_mem[$];
   logic [255:0]  r[8];

   core2_result_writeback dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .count       (count),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_rd_en  (fifo_rd_en),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_ready   (mem_ready),
      .busy        (busy),
      .done        (done),
      .result_cnt  (result_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: read data appears the cycle after the pop
   always @(posedge clk) begin
      if (fifo_rd_en && fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
   end

   always @(posedge clk) begin
      #2;
      fifo_empty = (fifo_mem.size() == 0);
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (fifo_rd_en) begin
            pops++;
            last_pop_cyc = cyc;
            checks++;
            if (fifo_empty) begin
               failures++;
               $display("FAIL pop_while_empty actual=1 required=0");
            end
         end
         if (mem_wr_en) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write actual addr=%h data=%h required none", mem_addr, mem_wr_data);
            end else begin
               if (mem_addr !== exp_wr_q[0].addr || mem_wr_data !== exp_wr_q[0].data) begin
                  failures++;
                  $display("FAIL write_beat actual addr=%h data=%h required addr=%h data=%h",
                           mem_addr, mem_wr_data, exp_wr_q[0].addr, exp_wr_q[0].data);
               end
               if (mem_ready) begin
                  void'(exp_wr_q.pop_front());
                  writes++;
               end else begin
                  stalls++;
               end
            end
         end
         if (done) begin
            checks++;
            if (exp_done_cyc_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_done actual cycle=%0d required none", cyc);
            end else begin
               if (cyc != exp_done_cyc_q[0]) begin
                  failures++;
                  $display("FAIL done_cycle actual=%0d required=%0d", cyc, exp_done_cyc_q[0]);
               end
               checks++;
               if (result_cnt !== 8'(exp_done_cnt_q[0])) begin
                  failures++;
                  $display("FAIL done_result_cnt actual=%0d required=%0d", result_cnt, exp_done_cnt_q[0]);
               end
               void'(exp_done_cyc_q.pop_front());
               void'(exp_done_cnt_q.pop_front());
            end
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_result(input logic [15:0] addr, input logic [255:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data[127:0];
      exp_wr_q.push_back(w);
      w.addr = addr + 16'd1;
      w.data = data[255:128];
      exp_wr_q.push_back(w);
   endtask

   task automatic expect_done(input int at_cyc, input int cnt);
      exp_done_cyc_q.push_back(at_cyc);
      exp_done_cnt_q.push_back(cnt);
   endtask

   task automatic wait_quiet(input string nm);
      int n;
      n = 0;
      while ((busy || exp_wr_q.size() != 0 || exp_done_cyc_q.size() != 0) && n < 80) begin
         next_cyc();
         n++;
      end
      checks++;
      if (n >= 80) begin
         failures++;
         $display("FAIL %s_timeout actual busy=%0d pending_writes=%0d pending_done=%0d required 0",
                  nm, busy, exp_wr_q.size(), exp_done_cyc_q.size());
         exp_wr_q.delete();
         exp_done_cyc_q.delete();
         exp_done_cnt_q.delete();
      end
   endtask

   initial begin
      int c;
      int p0;
      int w0;
      int s0;
      for (int i = 0; i < 8; i++) begin
         r[i] = {64'hDEAD_0000_0000_0000 + 64'(i), 64'hBEEF_0000_0000_0000 + 64'(i),
                 64'hCAFE_0000_0000_0000 + 64'(i), 64'hF00D_0000_0000_0000 + 64'(i)};
      end
      rst_n = 1'b0;
      start = 1'b0;
      base_addr = '0;
      count = '0;
      mem_ready = 1'b1;

      // Reset state
      #3;
      chk("rst_fifo_rd_en", 256'(fifo_rd_en), 256'd0);
      chk("rst_mem_wr_en", 256'(mem_wr_en), 256'd0);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_done", 256'(done), 256'd0);
      chk("rst_mem_addr", 256'(mem_addr), 256'd0);
      chk("rst_mem_wr_data", 256'(mem_wr_data), 256'd0);
      chk("rst_result_cnt", 256'(result_cnt), 256'd0);
      next_cyc();
      next_cyc();
      rst_n = 1'b1;
      next_cyc();

      // Basic transfer: two results from 0x0100, done 9 cycles after the start cycle
      fifo_mem.push_back(r[0]);
      fifo_mem.push_back(r[1]);
      expect_result(16'h0100, r[0]);
      expect_result(16'h0102, r[1]);
      c = cyc;
      p0 = pops;
      expect_done(c + 9, 2);
      start = 1'b1; base_addr = 16'h0100; count = 8'd2;
      next_cyc();
      start = 1'b0;
      wait_quiet("basic");
      chk("basic_pops", 256'(pops - p0), 256'd2);
      next_cyc();
      chk("basic_cnt_held", 256'(result_cnt), 256'd2);
      chk("basic_idle", 256'(busy), 256'd0);

      // Zero count: done in the cycle after start, nothing popped or written
      c = cyc;
      p0 = pops;
      w0 = writes;
      expect_done(c + 1, 0);
      start = 1'b1; base_addr = 16'h0123; count = 8'd0;
      next_cyc();
      start = 1'b0;
      wait_quiet("zero");
      chk("zero_pops", 256'(pops - p0), 256'd0);
      chk("zero_writes", 256'(writes - w0), 256'd0);
      chk("zero_result_cnt", 256'(result_cnt), 256'd0);

      // Backpressure: mem_ready low for the first three WR_LO cycles
      fifo_mem.push_back(r[2]);
      expect_result(16'h0200, r[2]);
      c = cyc;
      s0 = stalls;
      expect_done(c + 8, 1);
      start = 1'b1; base_addr = 16'h0200; count = 8'd1;
      mem_ready = 1'b0;
      next_cyc();
      start = 1'b0;
      repeat (5) next_cyc();
      mem_ready = 1'b1;
      wait_quiet("backpressure");
      chk("bp_stall_cycles", 256'(stalls - s0), 256'd3);

      // Empty FIFO stall: data only arrives five cycles into READ
      expect_result(16'h0300, r[3]);
      c = cyc;
      p0 = pops;
      expect_done(c + 10, 1);
      start = 1'b1; base_addr = 16'h0300; count = 8'd1;
      next_cyc();
      start = 1'b0;
      repeat (5) next_cyc();
      fifo_mem.push_back(r[3]);
      wait_quiet("empty_stall");
      chk("stall_pop_cycle", 256'(last_pop_cyc), 256'(c + 6));
      chk("stall_pops", 256'(pops - p0), 256'd1);

      // Address wrap from 0xFFFF to 0x0000
      fifo_mem.push_back(r[4]);
      expect_result(16'hFFFF, r[4]);
      c = cyc;
      expect_done(c + 5, 1);
      start = 1'b1; base_addr = 16'hFFFF; count = 8'd1;
      next_cyc();
      start = 1'b0;
      wait_quiet("wrap");

      // Reset during WR_HI of the second result; a start while busy is ignored
      fifo_mem.push_back(r[5]);
      fifo_mem.push_back(r[6]);
      expect_result(16'h0400, r[5]);
      begin
         wr_t w;
         w.addr = 16'h0402;
         w.data = r[6][127:0];
         exp_wr_q.push_back(w);
      end
      c = cyc;
      start = 1'b1; base_addr = 16'h0400; count = 8'd2;
      next_cyc();
      start = 1'b0;
      next_cyc();
      start = 1'b1; base_addr = 16'h0AAA; count = 8'd5;
      next_cyc();
      start = 1'b0; base_addr = '0; count = '0;
      repeat (5) next_cyc();
      chk("mid_cnt_before_rst", 256'(result_cnt), 256'd1);
      chk("mid_addr_before_rst", 256'(mem_addr), 256'h0403);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outputs",
          256'({fifo_rd_en, mem_wr_en, busy, done, mem_addr, mem_wr_data, result_cnt}), 256'd0);
      fifo_mem.delete();
      next_cyc();
      next_cyc();
      chk("mid_pending_writes", 256'(exp_wr_q.size()), 256'd0);
      // Release and start on the very first edge afterwards
      fifo_mem.push_back(r[7]);
      expect_result(16'h0500, r[7]);
      c = cyc;
      expect_done(c + 5, 1);
      rst_n = 1'b1;
      start = 1'b1; base_addr = 16'h0500; count = 8'd1;
      next_cyc();
      start = 1'b0;
      wait_quiet("after_reset");
      chk("after_reset_cnt", 256'(result_cnt), 256'd1);

      repeat (3) next_cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
